pipe_ctrl: RTL and testbench



---
 rtl/pipe_ctrl_pkg.sv | 41 ++++
 rtl/pipe_ctrl_if.sv | 46 ++++
 rtl/pipe_ctrl_mem_wait_timer.sv | 48 ++++
 rtl/pipe_ctrl.sv | 126 ++++++++++++
 tb/tb_pipe_ctrl.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared opcodes, FSM codes and widths for the pipeline hazard controller.
// Imported by the interface, the wait timer and the controller top.
package pipe_ctrl_pkg;

  localparam int REG_W = 5;
  localparam int OP_W  = 7;
  localparam int ST_W  = 2;

  localparam logic [OP_W-1:0] OP_LOAD = 7'b0000011;

  typedef enum logic [ST_W-1:0] {
    ST_RUN     = 2'd0,
    ST_MC_BUSY = 2'd1,
    ST_HALT    = 2'd2
  } state_t;

  typedef struct packed {
    logic f;
    logic d;
    logic e;
    logic m;
  } stall_t;

  typedef struct packed {
    logic d;
    logic e;
    logic m;
    logic w;
  } bubble_t;

  function automatic logic load_use(
    input logic [OP_W-1:0]  op,
    input logic [REG_W-1:0] rd,
    input logic [REG_W-1:0] rs1,
    input logic [REG_W-1:0] rs2
  );
    return (op == OP_LOAD) && (rd != '0) &&
           ((rd == rs1) || (rd == rs2));
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Datapath <-> hazard controller bundle: decoded fields and handshakes in,
// per-stage stall/bubble strobes and status out.
interface pipe_ctrl_if;
  import pipe_ctrl_pkg::*;

  logic [REG_W-1:0] d_rs1_i;
  logic [REG_W-1:0] d_rs2_i;
  logic [OP_W-1:0]  E_opcode_i;
  logic [REG_W-1:0] E_rd_i;
  logic             e_mispredict_i;
  logic             e_mc_start_i;
  logic             m_mem_req_i;
  logic             m_mem_ready_i;
  logic             w_halt_i;

  logic             F_stall_o;
  logic             D_stall_o;
  logic             E_stall_o;
  logic             M_stall_o;
  logic             D_bubble_o;
  logic             E_bubble_o;
  logic             M_bubble_o;
  logic             W_bubble_o;
  logic             halted_o;
  logic             mem_timeout_o;
  logic [ST_W-1:0]  ctrl_state_o;

  modport master (
    output d_rs1_i, d_rs2_i, E_opcode_i, E_rd_i,
    output e_mispredict_i, e_mc_start_i,
    output m_mem_req_i, m_mem_ready_i, w_halt_i,
    input  F_stall_o, D_stall_o, E_stall_o, M_stall_o,
    input  D_bubble_o, E_bubble_o, M_bubble_o, W_bubble_o,
    input  halted_o, mem_timeout_o, ctrl_state_o
  );

  modport slave (
    input  d_rs1_i, d_rs2_i, E_opcode_i, E_rd_i,
    input  e_mispredict_i, e_mc_start_i,
    input  m_mem_req_i, m_mem_ready_i, w_halt_i,
    output F_stall_o, D_stall_o, E_stall_o, M_stall_o,
    output D_bubble_o, E_bubble_o, M_bubble_o, W_bubble_o,
    output halted_o, mem_timeout_o, ctrl_state_o
  );

endinterface

// File: rtl/pipe_ctrl_mem_wait_timer.sv
// Counts consecutive data-memory wait cycles; flags a sticky timeout and
// emits a one-cycle pulse to the controller FSM when the limit is reached.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic i_hold,
  output logic o_timeout,
  output logic o_tmo_pulse
);

  localparam int W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [W-1:0] LIMIT = W'(MEM_TIMEOUT);
  localparam logic [W-1:0] LAST  = W'(MEM_TIMEOUT - 1);

  logic [W-1:0] r_cnt;
  logic         r_tmo;
  logic         r_pulse;
  logic         w_hit;

  assign w_hit = i_hold && (r_cnt == LAST);

  // Count saturates at the limit so a long stall never wraps.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cnt <= '0;
    end else if (!i_hold) begin
      r_cnt <= '0;
    end else if (r_cnt != LIMIT) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_tmo   <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_tmo   <= r_tmo | w_hit;
      r_pulse <= w_hit & ~r_tmo;
    end
  end

  assign o_timeout   = r_tmo;
  assign o_tmo_pulse = r_pulse;

endmodule

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline hazard controller: load-use, mispredict flush,
// multi-cycle execute, memory wait states and halt.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MC_CYCLES   = 4,
  parameter int MEM_TIMEOUT = 255
) (
  input logic       clk_i,
  input logic       rst_n_i,
  pipe_ctrl_if.slave bus
);

  localparam int MCW = (MC_CYCLES > 2) ? $clog2(MC_CYCLES) : 1;
  localparam logic [MCW-1:0] MC_LOAD = MCW'(MC_CYCLES - 1);

  state_t         r_state;
  state_t         w_state_n;
  logic [MCW-1:0] r_mc_cnt;
  logic [MCW-1:0] w_mc_cnt_n;

  logic    w_mem_hold;
  logic    w_load_use;
  logic    w_mc_busy;
  logic    w_timeout;
  logic    w_tmo_pulse;
  stall_t  w_stall;
  bubble_t w_bubble;

  assign w_mem_hold = bus.m_mem_req_i & ~bus.m_mem_ready_i;

  assign w_load_use = load_use(bus.E_opcode_i, bus.E_rd_i,
                               bus.d_rs1_i, bus.d_rs2_i);

  assign w_mc_busy =
    ((r_state == ST_RUN) & bus.e_mc_start_i) |
    ((r_state == ST_MC_BUSY) & (r_mc_cnt != '0));

  mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_wait (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .i_hold      (w_mem_hold),
    .o_timeout   (w_timeout),
    .o_tmo_pulse (w_tmo_pulse)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state  <= ST_RUN;
      r_mc_cnt <= '0;
    end else begin
      r_state  <= w_state_n;
      r_mc_cnt <= w_mc_cnt_n;
    end
  end

  always_comb begin
    w_state_n  = r_state;
    w_mc_cnt_n = r_mc_cnt;
    case (r_state)
      ST_RUN: begin
        // A held E keeps e_mc_start_i up, so the op starts once hold clears.
        if (bus.e_mc_start_i && !w_mem_hold) begin
          w_state_n  = ST_MC_BUSY;
          w_mc_cnt_n = MC_LOAD;
        end
      end
      ST_MC_BUSY: begin
        if (r_mc_cnt != '0) begin
          w_mc_cnt_n = r_mc_cnt - 1'b1;
        end
        if (r_mc_cnt == '0 && !w_mem_hold) begin
          w_state_n = ST_RUN;
        end
      end
      ST_HALT: begin
        w_state_n = ST_HALT;
      end
      default: begin
        w_state_n  = ST_RUN;
        w_mc_cnt_n = '0;
      end
    endcase
    if (bus.w_halt_i || w_tmo_pulse) begin
      w_state_n = ST_HALT;
    end
  end

  always_comb begin
    w_stall  = '0;
    w_bubble = '0;
    if (!rst_n_i) begin
      w_bubble = '1;
    end else if (r_state == ST_HALT || w_mem_hold) begin
      w_stall    = '1;
      w_bubble.w = 1'b1;
    end else if (w_mc_busy) begin
      w_stall.f  = 1'b1;
      w_stall.d  = 1'b1;
      w_stall.e  = 1'b1;
      w_bubble.m = 1'b1;
    end else if (bus.e_mispredict_i) begin
      w_bubble.d = 1'b1;
      w_bubble.e = 1'b1;
    end else if (w_load_use) begin
      w_stall.f  = 1'b1;
      w_stall.d  = 1'b1;
      w_bubble.e = 1'b1;
    end
  end

  assign bus.F_stall_o     = w_stall.f;
  assign bus.D_stall_o     = w_stall.d;
  assign bus.E_stall_o     = w_stall.e;
  assign bus.M_stall_o     = w_stall.m;
  assign bus.D_bubble_o    = w_bubble.d;
  assign bus.E_bubble_o    = w_bubble.e;
  assign bus.M_bubble_o    = w_bubble.m;
  assign bus.W_bubble_o    = w_bubble.w;
  assign bus.halted_o      = (r_state == ST_HALT);
  assign bus.mem_timeout_o = w_timeout;
  assign bus.ctrl_state_o  = r_state;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed hazard sequences then random
// stimulus, checked against a cycle-timestamp reference model.
module tb_pipe_ctrl;

  localparam int MC = 4;
  localparam int MT = 4;
  localparam logic [6:0] LOAD = 7'b0000011;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [6:0] op;
    logic [4:0] rd;
    logic       mp;
    logic       mcs;
    logic       req;
    logic       rdy;
    logic       halt;
  } stim_t;

  logic clk;
  logic rst_n;

  pipe_ctrl_if bus ();

  pipe_ctrl #(
    .MC_CYCLES   (MC),
    .MEM_TIMEOUT (MT)
  ) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [11:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  // Reference model: multi-cycle occupancy by start timestamp, hold streaks
  // as plain integers, halt as a flag with a one-cycle delayed timeout path.
  int cyc = 0;
  bit m_halted, m_hpend, m_tmo, m_inmc;
  int m_start, m_streak;

  function automatic logic [11:0] expect_of(input stim_t s);
    logic [3:0] st;
    logic [3:0] bb;
    logic [1:0] stv;
    logic hold, lu, mcb;
    st   = 4'b0000;
    bb   = 4'b0000;
    hold = s.req && !s.rdy;
    lu   = (s.op == LOAD) && (s.rd != 0) &&
           (s.rd == s.rs1 || s.rd == s.rs2);
    mcb  = m_inmc ? ((cyc - m_start) < MC) : s.mcs;
    if (!s.rst) begin
      bb = 4'b1111;
    end else if (m_halted || hold) begin
      st = 4'b1111;
      bb = 4'b0001;
    end else if (mcb) begin
      st = 4'b1110;
      bb = 4'b0010;
    end else if (s.mp) begin
      bb = 4'b1100;
    end else if (lu) begin
      st = 4'b1100;
      bb = 4'b0100;
    end
    if (!s.rst) stv = 2'd0;
    else if (m_halted) stv = 2'd2;
    else if (m_inmc) stv = 2'd1;
    else stv = 2'd0;
    return {st, bb, s.rst && m_halted, s.rst && m_tmo, stv};
  endfunction

  task automatic model_update(input stim_t s);
    bit hold, nh;
    if (!s.rst) begin
      m_halted = 0;
      m_hpend  = 0;
      m_tmo    = 0;
      m_inmc   = 0;
      m_streak = 0;
    end else begin
      hold = s.req && !s.rdy;
      nh   = m_halted || s.halt || m_hpend;
      m_hpend = 0;
      if (hold) begin
        m_streak++;
        if (m_streak == MT && !m_tmo) begin
          m_tmo   = 1;
          m_hpend = 1;
        end
      end else begin
        m_streak = 0;
      end
      if (!m_halted) begin
        if (m_inmc) begin
          if ((cyc - m_start) >= MC && !hold) m_inmc = 0;
        end else if (s.mcs && !hold) begin
          m_inmc  = 1;
          m_start = cyc;
        end
      end
      m_halted = nh;
    end
    cyc++;
  endtask

  task automatic drive(input stim_t s);
    rst_n              = s.rst;
    bus.d_rs1_i        = s.rs1;
    bus.d_rs2_i        = s.rs2;
    bus.E_opcode_i     = s.op;
    bus.E_rd_i         = s.rd;
    bus.e_mispredict_i = s.mp;
    bus.e_mc_start_i   = s.mcs;
    bus.m_mem_req_i    = s.req;
    bus.m_mem_ready_i  = s.rdy;
    bus.w_halt_i       = s.halt;
  endtask

  task automatic step(input stim_t s);
    drive(s);
    exp_q.push_back(expect_of(s));
    model_update(s);
    @(posedge clk);
    #1;
  endtask

  function automatic stim_t idle();
    stim_t s;
    s     = '0;
    s.rst = 1'b1;
    s.rdy = 1'b1;
    return s;
  endfunction

  always @(negedge clk) begin
    logic [11:0] act, want;
    if (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      act  = {bus.F_stall_o, bus.D_stall_o, bus.E_stall_o, bus.M_stall_o,
              bus.D_bubble_o, bus.E_bubble_o, bus.M_bubble_o, bus.W_bubble_o,
              bus.halted_o, bus.mem_timeout_o, bus.ctrl_state_o};
      n_cmp++;
      if (act !== want) begin
        n_err++;
        $display("FAIL ctrl t=%0t: got FDEM/DEMW/h/t/st=%b want %b",
                 $time, act, want);
      end
    end
  end

  initial begin
    stim_t s;
    s = idle();
    s.rst = 1'b0;
    drive(s);
    @(posedge clk);
    #1;
    step(s);
    step(s);
    repeat (2) step(idle());

    // load-use, then no interlock on x0
    s = idle(); s.op = LOAD; s.rd = 5'd5; s.rs1 = 5'd5;
    step(s);
    step(idle());
    s = idle(); s.op = LOAD; s.rd = 5'd0; s.rs1 = 5'd0;
    step(s);

    // mispredict beats load-use
    s = idle(); s.op = LOAD; s.rd = 5'd3; s.rs2 = 5'd3; s.mp = 1'b1;
    step(s);
    step(idle());

    // plain multi-cycle op
    s = idle(); s.mcs = 1'b1;
    step(s);
    repeat (6) step(idle());

    // multi-cycle op with a 3-cycle memory wait inside it
    s = idle(); s.mcs = 1'b1;
    step(s);
    step(idle());
    s = idle(); s.req = 1'b1; s.rdy = 1'b0;
    repeat (3) step(s);
    s = idle(); s.req = 1'b1;
    step(s);
    repeat (2) step(idle());

    // mem_hold and mc start together in RUN
    s = idle(); s.mcs = 1'b1; s.req = 1'b1; s.rdy = 1'b0;
    step(s);
    s = idle(); s.mcs = 1'b1;
    step(s);
    repeat (5) step(idle());

    // halt, then reset mid-halt
    s = idle(); s.halt = 1'b1;
    step(s);
    repeat (3) step(idle());
    s = idle(); s.rst = 1'b0;
    step(s);
    repeat (2) step(idle());

    // memory timeout
    s = idle(); s.req = 1'b1; s.rdy = 1'b0;
    repeat (8) step(s);
    repeat (2) step(idle());
    s = idle(); s.rst = 1'b0;
    step(s);
    repeat (2) step(idle());

    for (int i = 0; i < 800; i++) begin
      s      = idle();
      s.rst  = ($urandom_range(0, 99) != 0);
      s.rs1  = 5'($urandom_range(0, 3));
      s.rs2  = 5'($urandom_range(0, 3));
      s.rd   = 5'($urandom_range(0, 3));
      s.op   = ($urandom_range(0, 1) != 0) ? LOAD : 7'($urandom);
      s.mp   = ($urandom_range(0, 5) == 0);
      s.mcs  = ($urandom_range(0, 9) == 0);
      s.req  = ($urandom_range(0, 2) == 0);
      s.rdy  = ($urandom_range(0, 1) != 0);
      s.halt = ($urandom_range(0, 199) == 0);
      step(s);
    end
    step(idle());
    @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d entries left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
